// File: rtl/seven_seg_scan_pkg.sv
// seven_seg_scan_pkg: active-high segment patterns {a..g} and the digit-index width helper
package seven_seg_pkg;
  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: control (en, load, value) in, display pins (seg, an, frame_done) out
interface seven_seg_scan_if #(parameter int NUM_DIGITS = 4);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;
  modport master (output en, load, value, input seg, an, frame_done);
  modport slave (input en, load, value, output seg, an, frame_done);
endinterface

// File: rtl/seven_seg_scan_bcd_to_seg7.sv
// bcd_to_seg7: combinational nibble -> active-high {a..g}; nibbles 10..15 decode blank
module bcd_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: N-digit multiplexed BCD 7-seg driver; ports clk, rst, bus (slave: en/load/value in, seg/an/frame_done out); SEVEN_SEG_LZB_EN enables leading-zero blanking
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic            clk,
  input logic            rst,
  seven_seg_scan_if.slave bus
);
  localparam int IW = idx_w(NUM_DIGITS);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [6:0] SPOL = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] APOL = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
  logic [4*NUM_DIGITS-1:0] word;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [3:0]              nib;
  logic [6:0]              pat;
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    last_cnt, wrap, show, dig_blank;
  assign nib = word[4*idx +: 4];
  bcd_to_seg7 u_dec (.nib(nib), .seg(pat));
`ifdef SEVEN_SEG_LZB_EN
  // blank when every nibble from idx upward is zero; digit 0 always shows
  assign dig_blank = (idx != '0) && ((word >> (4*idx)) == '0);
`else
  assign dig_blank = 1'b0;
`endif
  always_comb begin
    last_cnt = cnt == CW'(PRESCALE - 1);
    wrap     = bus.en && last_cnt && idx == IW'(NUM_DIGITS - 1);
    show     = bus.en && cnt >= CW'(BLANK_CYCLES);
    seg_n    = (show && !dig_blank) ? pat : SEG_OFF;
    an_n     = show ? NUM_DIGITS'(1) << idx : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      word           <= '0;
      cnt            <= '0;
      idx            <= '0;
      bus.seg        <= SEG_OFF ^ SPOL;
      bus.an         <= APOL;
      bus.frame_done <= 1'b0;
    end else begin
      if (bus.load) word <= bus.value;
      if (bus.en) begin
        cnt <= last_cnt ? '0 : cnt + 1'b1;
        if (last_cnt) idx <= wrap ? '0 : idx + 1'b1;
      end
      bus.seg        <= seg_n ^ SPOL;
      bus.an         <= an_n ^ APOL;
      bus.frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed checks of reset, scan order, decode, freeze, load collision and blanking
module tb_seven_seg_scan;
`ifdef SEVEN_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
  localparam logic [6:0] S9 = 7'b1111011, SOFF = 7'b0000000;
  localparam logic [6:0] SLZ0 = LZB ? SOFF : S0;
  logic clk, rst;
  int   k, errors, checks;
  seven_seg_scan_if #(.NUM_DIGITS(4)) bus ();
  seven_seg_scan #(
    .NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    if (bus.en && !rst) k++;
    @(negedge clk);
  endtask
  task automatic step_to(input int t);
    for (int n = 0; n < 1000 && k < t; n++) step();
    checks++;
    assert (k == t) else begin errors++; $error("FAIL step_to: reached k=%0d want %0d", k, t); end
  endtask
  task automatic chk(input string tag, input logic [6:0] es, input logic [3:0] ea, input logic ef);
    checks++;
    assert (bus.seg === es) else begin errors++; $error("FAIL %s seg: got %b want %b", tag, bus.seg, es); end
    checks++;
    assert (bus.an === ea) else begin errors++; $error("FAIL %s an: got %b want %b", tag, bus.an, ea); end
    checks++;
    assert (bus.frame_done === ef) else begin errors++; $error("FAIL %s frame_done: got %b want %b", tag, bus.frame_done, ef); end
  endtask
  initial begin
    errors = 0; checks = 0; k = 0;
    rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.value = '0;
    repeat (3) step();
    chk("reset", SOFF, 4'b1111, 1'b0);
    rst = 1'b0; bus.en = 1'b1; bus.load = 1'b1; bus.value = 16'h1234;
    step(); bus.load = 1'b0;
    chk("blank1", SOFF, 4'b1111, 1'b0);
    step();
    chk("blank2", SOFF, 4'b1111, 1'b0);
    step();
    chk("d0_4", S4, 4'b1110, 1'b0);
    step_to(11); chk("d1_3", S3, 4'b1101, 1'b0);
    step_to(19); chk("d2_2", S2, 4'b1011, 1'b0);
    step_to(27); chk("d3_1", S1, 4'b0111, 1'b0);
    step_to(31); chk("pre_fd", S1, 4'b0111, 1'b0);
    step_to(32); chk("fd1", S1, 4'b0111, 1'b1);
    step_to(33); chk("post_fd", SOFF, 4'b1111, 1'b0);
    step_to(63); chk("pre_fd2", S1, 4'b0111, 1'b0);
    step_to(64); chk("fd2", S1, 4'b0111, 1'b1);
    bus.load = 1'b1; bus.value = 16'h00F9;
    step(); bus.load = 1'b0;
    step_to(67); chk("f9_d0", S9, 4'b1110, 1'b0);
    step_to(75); chk("f9_d1", SOFF, 4'b1101, 1'b0);
    step_to(83); chk("f9_d2", SLZ0, 4'b1011, 1'b0);
    step_to(96); chk("f9_fd", SLZ0, 4'b0111, 1'b1);
    step_to(101); chk("pre_frz", S9, 4'b1110, 1'b0);
    bus.en = 1'b0;
    step(); chk("frz1", SOFF, 4'b1111, 1'b0);
    repeat (9) step();
    chk("frz10", SOFF, 4'b1111, 1'b0);
    bus.en = 1'b1;
    step(); chk("resume", S9, 4'b1110, 1'b0);
    step_to(104); chk("resume_end", S9, 4'b1110, 1'b0);
    step_to(105); chk("resume_next", SOFF, 4'b1111, 1'b0);
    step_to(135);
    bus.load = 1'b1; bus.value = 16'h5678;
    step(); bus.load = 1'b0;
    chk("coll_old", S9, 4'b1110, 1'b0);
    step_to(138); chk("coll_blank", SOFF, 4'b1111, 1'b0);
    step_to(139); chk("coll_d1", S7, 4'b1101, 1'b0);
    step_to(147); chk("coll_d2", S6, 4'b1011, 1'b0);
    step_to(160); chk("coll_fd", S5, 4'b0111, 1'b1);
    bus.load = 1'b1; bus.value = 16'h0007;
    step(); bus.load = 1'b0;
    step_to(163); chk("lz7_d0", S7, 4'b1110, 1'b0);
    step_to(171); chk("lz7_d1", SLZ0, 4'b1101, 1'b0);
    step_to(187); chk("lz7_d3", SLZ0, 4'b0111, 1'b0);
    step_to(192);
    bus.load = 1'b1; bus.value = 16'h0000;
    step(); bus.load = 1'b0;
    step_to(195); chk("lz0_d0", S0, 4'b1110, 1'b0);
    step_to(203); chk("lz0_d1", SLZ0, 4'b1101, 1'b0);
    step_to(205);
    rst = 1'b1;
    step(); chk("mid_rst", SOFF, 4'b1111, 1'b0);
    rst = 1'b0; k = 0;
    step_to(2); chk("rst_blank", SOFF, 4'b1111, 1'b0);
    step_to(3); chk("rst_d0", S0, 4'b1110, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Parametrised, time-multiplexed N-digit BCD seven-segment display driver.
- Captures a packed BCD word on a load strobe and scans one digit at a time, with a prescaled refresh rate and an anti-ghosting blank interval.
- Provides configurable segment and anode polarity.
- Sits between datapath result registers and the board's shared segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- PRESCALE, 50000, clock cycles per digit slot (>= 2).
- BLANK_CYCLES, 2, cycles at the start of each slot with all anodes inactive (0..PRESCALE-1).
- SEG_ACTIVE_LOW, 0, 1 = segment outputs inverted.
- AN_ACTIVE_LOW, 1, 1 = anode outputs inverted.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, scan enable.
- load, input, 1, capture strobe for value.
- value, input, 4*NUM_DIGITS, packed BCD; nibble i = digit i, digit 0 = rightmost.
- seg, output, 7, segments {a,b,c,d,e,f,g}, a = bit 6, g = bit 0.
- an, output, NUM_DIGITS, one-hot digit select.
- frame_done, output, 1, one-cycle pulse per completed scan frame.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset, on the rising edge with rst=1:
  - stored word = 0, prescaler cnt = 0, digit index idx = 0.
  - seg = all segments off (after polarity).
  - an = all inactive (after polarity).
  - frame_done = 0.
  - Reset mid-scan aborts the slot immediately; no partial frame_done.
- Capture:
  - load=1 latches value into the stored word at the clock edge, regardless of en.
  - Decode uses the stored word only, never live value.
- Prescaler (advances only while en=1):
  - cnt counts 0..PRESCALE-1.
  - At cnt=PRESCALE-1: cnt -> 0 and idx -> idx+1, wrapping NUM_DIGITS-1 -> 0.
- frame_done = 1 for exactly one cycle, registered, in the cycle after idx wraps NUM_DIGITS-1 -> 0.
- Outputs are registered and lag the internal state (idx, cnt) by one cycle.
- Output rules for the current (idx, cnt):
  - en=0: an all inactive, seg off; cnt and idx hold their values.
  - cnt < BLANK_CYCLES: an all inactive, seg off.
  - Otherwise: an bit idx active, all other bits inactive; seg = decode(stored nibble idx).
- Decode (active-high, before polarity):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Nibble 10..15 = 0000000 (blank).
- Polarity: SEG_ACTIVE_LOW / AN_ACTIVE_LOW invert the final registered outputs, including the reset values.
- load in the same cycle as a slot change: the new word is used from the next cycle's decode; the old word is never shown in the new slot.
- NUM_DIGITS=1: idx stays 0, and frame_done pulses every PRESCALE enabled cycles.

Optional Feature:
- Macro: SEVEN_SEG_LZB_EN (leading-zero blanking).
- When defined:
  - Digits above the most significant non-zero nibble of the stored word show seg off.
  - an stays active for those digits, so timing is unchanged.
  - Digit 0 is never blanked; a stored word of 0 shows a single "0".
  - Blank mask is recomputed from the stored word every cycle.
- When undefined: all digits display, including leading zeros.

Decomposition:
- Package seven_seg_pkg holds:
  - Localparams SEG_0..SEG_9 and SEG_OFF (7-bit, active-high).
  - Function width helper for idx: clog2 of NUM_DIGITS, minimum 1.
- Sub-module bcd_to_seg7: purely combinational nibble -> 7-bit active-high pattern using the package constants.
- Instantiated once, on the muxed nibble.

Test Plan (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1):
- Reset: rst held 3 cycles -> seg=0000000, an=1111, frame_done=0; after release with en=1, first slot shows an=1111 for 2 cycles, then an=1110.
- Scan: load value=16'h1234, en=1 -> slots in order:
  - an=1110 seg=0110011 (4)
  - an=1101 seg=1111001 (3)
  - an=1011 seg=1101101 (2)
  - an=0111 seg=0110000 (1)
  - frame_done pulses once per 32 cycles.
- Invalid BCD: value=16'h00F9 -> digit 0 seg=1111011, digit 1 seg=0000000; idx wraps with no error.
- Enable freeze: drop en mid-slot at cnt=5 for 10 cycles -> an=1111, seg=0000000; on re-enable, the slot resumes at cnt=5 with the same idx.
- Load collision: load=16'h5678 on the cycle idx advances 0->1 -> the next lit digit shows 7 (1110000), never the old nibble.
- SEVEN_SEG_LZB_EN: value=16'h0007 -> digits 3..1 seg=0000000, digit 0 seg=1110000; value=16'h0000 -> digit 0 seg=1111110 only.
